// File: rtl/time_set_ctrl.sv
// time_set_ctrl: manual time-setting sequencer for the four BCD clock digits.
// On entry to edit mode it freezes counting and copies the live time into
// shadow digits. The user then edits one digit at a time, and each digit wraps
// within its legal range. Commit loads all four digit registers in parallel.
// Optional feature macro: AUTO_TIMEOUT_EN. When it is defined, an edit session
// that sees no button press for TIMEOUT_S tick_1hz periods is abandoned.
module time_set_ctrl #(
  parameter int TIMEOUT_S = 10
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       tick_1hz,
  input  logic       mode_btn,
  input  logic       up_btn,
  input  logic       down_btn,
  input  logic       cancel_btn,
  input  logic [3:0] cur_hr_t,
  input  logic [3:0] cur_hr_u,
  input  logic [3:0] cur_min_t,
  input  logic [3:0] cur_min_u,
  output logic       run_en,
  output logic       set_all,
  output logic       sec_clr,
  output logic [3:0] new_hr_t,
  output logic [3:0] new_hr_u,
  output logic [3:0] new_min_t,
  output logic [3:0] new_min_u,
  output logic [1:0] edit_digit,
  output logic       editing
);

  typedef enum logic [2:0] {
    S_RUN, S_EDIT_HT, S_EDIT_HU, S_EDIT_MT, S_EDIT_MU, S_COMMIT
  } state_t;

  state_t     state, state_nxt;
  logic       timeout;
  logic       any_btn;
  logic       edit_step;
  logic [3:0] hr_u_max;
  logic [3:0] ht_next;

  // Increment with wrap. A value already above the maximum also wraps to 0.
  function automatic logic [3:0] wrap_up(input logic [3:0] d, input logic [3:0] mx);
    return (d >= mx) ? 4'd0 : d + 4'd1;
  endfunction

  // Decrement with wrap. An out-of-range value is pulled back to 0.
  function automatic logic [3:0] wrap_dn(input logic [3:0] d, input logic [3:0] mx);
    if (d == 4'd0) return mx;
    if (d > mx)    return 4'd0;
    return d - 4'd1;
  endfunction

  function automatic logic [3:0] step_digit(input logic [3:0] d, input logic [3:0] mx,
                                            input logic up);
    return up ? wrap_up(d, mx) : wrap_dn(d, mx);
  endfunction

  assign any_btn   = mode_btn | up_btn | down_btn | cancel_btn;
  assign hr_u_max  = (new_hr_t == 4'd2) ? 4'd3 : 4'd9;
  assign ht_next   = step_digit(new_hr_t, 4'd2, up_btn);
  // A digit is edited only when no higher-priority button is present and exactly one of up/down is pressed.
  assign edit_step = editing & ~cancel_btn & ~timeout & ~mode_btn & (up_btn ^ down_btn);

`ifdef AUTO_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_S + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_S - 1);
  logic [CW-1:0] idle_cnt;

  // Idle-seconds counter. It is held at 0 outside edit and cleared by any button press.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                   idle_cnt <= '0;
    else if (!editing || any_btn)  idle_cnt <= '0;
    else if (tick_1hz)             idle_cnt <= idle_cnt + CW'(1);
  end

  // The tick that would bring the counter to TIMEOUT_S aborts the edit.
  assign timeout = editing & tick_1hz & ~any_btn & (idle_cnt == TMO_LAST);
`else
  localparam int unused_timeout_s = TIMEOUT_S;
  logic unused_tick;
  assign unused_tick = tick_1hz;
  assign timeout     = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_RUN;
    else         state <= state_nxt;
  end

  // Next-state logic. Cancel/timeout outrank mode; COMMIT always lasts one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN:     if (mode_btn) state_nxt = S_EDIT_HT;
      S_EDIT_HT: if (cancel_btn || timeout) state_nxt = S_RUN;
                 else if (mode_btn)         state_nxt = S_EDIT_HU;
      S_EDIT_HU: if (cancel_btn || timeout) state_nxt = S_RUN;
                 else if (mode_btn)         state_nxt = S_EDIT_MT;
      S_EDIT_MT: if (cancel_btn || timeout) state_nxt = S_RUN;
                 else if (mode_btn)         state_nxt = S_EDIT_MU;
      S_EDIT_MU: if (cancel_btn || timeout) state_nxt = S_RUN;
                 else if (mode_btn)         state_nxt = S_COMMIT;
      S_COMMIT:  state_nxt = S_RUN;
      default:   state_nxt = S_RUN;
    endcase
  end

  // Output decode from the current state
  always_comb begin
    run_en     = (state == S_RUN);
    set_all    = (state == S_COMMIT);
    sec_clr    = (state == S_COMMIT);
    editing    = 1'b0;
    edit_digit = 2'd0;
    case (state)
      S_EDIT_HT: begin editing = 1'b1; edit_digit = 2'd0; end
      S_EDIT_HU: begin editing = 1'b1; edit_digit = 2'd1; end
      S_EDIT_MT: begin editing = 1'b1; edit_digit = 2'd2; end
      S_EDIT_MU: begin editing = 1'b1; edit_digit = 2'd3; end
      default:   begin editing = 1'b0; edit_digit = 2'd0; end
    endcase
  end

  // Shadow digits: capture the live time on edit entry, then apply up/down to the selected digit
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      new_hr_t  <= 4'd0;
      new_hr_u  <= 4'd0;
      new_min_t <= 4'd0;
      new_min_u <= 4'd0;
    end else if (state == S_RUN && mode_btn) begin
      new_hr_t  <= cur_hr_t;
      new_hr_u  <= (cur_hr_t == 4'd2 && cur_hr_u > 4'd3) ? 4'd3 : cur_hr_u;
      new_min_t <= cur_min_t;
      new_min_u <= cur_min_u;
    end else if (edit_step) begin
      case (edit_digit)
        2'd0: begin
          new_hr_t <= ht_next;
          // Moving into the 20s hours: keep the hour at 23 or below.
          if (ht_next == 4'd2 && new_hr_u > 4'd3) new_hr_u <= 4'd3;
        end
        2'd1:    new_hr_u  <= step_digit(new_hr_u, hr_u_max, up_btn);
        2'd2:    new_min_t <= step_digit(new_min_t, 4'd5, up_btn);
        default: new_min_u <= step_digit(new_min_u, 4'd9, up_btn);
      endcase
    end
  end

endmodule
